led_pattern_sequencer: RTL

- Parametrised LED pattern generator for the board LED bank, driven from the 50 MHz board clock.
- Steps through one of four selectable patterns: chase right, chase left, ping-pong, and chase-then-blink.
- Step rate comes from a programmable prescaler with run-time speed select and pause.
- Emits a one-cycle step strobe for downstream logic such as a 7-segment step counter.

---
 rtl/led_seq_pkg.sv | 47 ++++
 rtl/led_pattern_sequencer_if.sv | 21 ++
 rtl/led_step_prescaler.sv | 39 +++
 rtl/led_pattern_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode encoding and pattern helpers for the LED pattern sequencer.
// Patterns are computed at the 32-bit maximum width; callers truncate to N_LED.
package led_seq_pkg;

    localparam int MAX_LED = 32;

    typedef enum logic [1:0] {
        MODE_CHASE_R     = 2'd0,
        MODE_CHASE_L     = 2'd1,
        MODE_PINGPONG    = 2'd2,
        MODE_CHASE_BLINK = 2'd3
    } mode_t;

    function automatic int seq_len(mode_t mode, int n_led, int blink_cnt);
        int len;
        case (mode)
            MODE_PINGPONG:    len = 2 * n_led - 2;
            MODE_CHASE_BLINK: len = n_led + 2 * blink_cnt;
            default:          len = n_led;
        endcase
        return len;
    endfunction

    function automatic logic [MAX_LED-1:0] pattern_decode(mode_t mode, int step, int n_led);
        logic [MAX_LED-1:0] r;
        int                 p;
        r = MAX_LED'(1) << (n_led - 1 - step);
        p = step;
        case (mode)
            MODE_CHASE_L: r = MAX_LED'(1) << step;
            MODE_PINGPONG: begin
                // Fold the return leg back so the end LEDs are not repeated.
                if (step >= n_led) p = 2 * n_led - 2 - step;
                r = MAX_LED'(1) << (n_led - 1 - p);
            end
            MODE_CHASE_BLINK: begin
                if (step >= n_led) begin
                    if (((step - n_led) % 2) != 0) r = (MAX_LED'(1) << n_led) - MAX_LED'(1);
                    else                           r = '0;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control and LED output bundle of the sequencer; master is the controller
// side (board logic / bench), slave is the sequencer itself.
interface led_pattern_sequencer_if #(
    parameter int N_LED = 8
);
    logic [1:0]       mode_i;
    logic [1:0]       speed_i;
    logic             pause_i;
    logic             step_o;
    logic [N_LED-1:0] LED_Output;

    modport master (
        output mode_i, speed_i, pause_i,
        input  step_o, LED_Output
    );

    modport slave (
        input  mode_i, speed_i, pause_i,
        output step_o, LED_Output
    );
endinterface

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts clocks toward max(STEP_DIV >> speed, 1) and
// emits a one-cycle tick; pause freezes the count, clear restarts it.
module led_step_prescaler #(
    parameter int STEP_DIV = 6_250_000
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       clear,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic       tick
);
    localparam logic [27:0] DIV = 28'(STEP_DIV);

    logic [27:0] cnt_q, cnt_d, period;

    always_comb begin
        period = DIV >> speed;
        if (period == '0) period = 28'd1;
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!pause) begin
            // >= so that a speed-up mid-step fires at once instead of wrapping.
            if (cnt_q >= period - 28'd1) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 28'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer top: holds the mode and step registers and the
// registered LED/strobe outputs; step timing comes from led_step_prescaler.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED     = 8,
    parameter int STEP_DIV  = 6_250_000,
    parameter int BLINK_CNT = 3
) (
    input  logic                   Clk_50MHz,
    input  logic                   Reset_Onboard,
    led_pattern_sequencer_if.slave bus
);
    localparam int STEP_W = $clog2(2 * N_LED + 2 * BLINK_CNT);

    mode_t             mode_q, mode_d, mode_in, nxt_mode;
    logic [STEP_W-1:0] step_q, step_d, nxt_step;
    logic [N_LED-1:0]  led_q, led_d, dec;
    logic              strobe_q, strobe_d;
    logic              mode_change, tick;

    assign mode_in     = mode_t'(bus.mode_i);
    assign mode_change = (mode_in != mode_q);

    led_step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .clk   (Clk_50MHz),
        .rst_b (Reset_Onboard),
        .clear (mode_change),
        .pause (bus.pause_i),
        .speed (bus.speed_i),
        .tick  (tick)
    );

    always_comb begin
        nxt_mode = mode_q;
        nxt_step = step_q + 1'b1;
        if (mode_change) begin
            nxt_mode = mode_in;
            nxt_step = '0;
        end else if (int'(step_q) == seq_len(mode_q, N_LED, BLINK_CNT) - 1) begin
            nxt_step = '0;
        end
        dec = N_LED'(pattern_decode(nxt_mode, int'(nxt_step), N_LED));

        mode_d   = mode_q;
        step_d   = step_q;
        led_d    = led_q;
        strobe_d = 1'b0;
        if (mode_change) begin
            mode_d = nxt_mode;
            step_d = '0;
            led_d  = dec;
        end else if (tick) begin
            step_d   = nxt_step;
            led_d    = dec;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_50MHz) begin
        if (!Reset_Onboard) begin
            mode_q   <= MODE_CHASE_R;
            step_q   <= '0;
            led_q    <= {1'b1, {(N_LED-1){1'b0}}};
            strobe_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            step_q   <= step_d;
            led_q    <= led_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.step_o     = strobe_q;
    assign bus.LED_Output = led_q;
endmodule
